nms_thin: RTL and testbench

NMS_THIN -- requirements
Module: nms_thin

---
 rtl/nms_thin.sv | 147 ++++++++++++++
 tb/tb_nms_thin.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/nms_thin.sv
// Non-maximum suppression over a raster stream of (direction, magnitude) gradient pixels.
// Two line buffers feed a 3x3 window; each pixel's output comes out two cycles after the pixel that completes its window.
module nms_thin #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 638
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        data_en,
  input  logic [25:0] grad_square,
  output logic        nms_en,
  output logic [23:0] nms_out,
  output logic        frame_done,
  output logic        overrun
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [FW-1:0] fcnt;
  logic [25:0]   lb1 [WIDTH];
  logic [25:0]   lb2 [WIDTH];
  logic [25:0]   win [3][3];
  logic          v1, zero1, last1;

  logic          accept, last_col, last_row, first_out, border;
  logic [CW-1:0] cc;
  logic [RW-1:0] cr;
  logic [23:0]   center, na, nb;
  logic          keep;

  assign accept    = start && data_en && (state == FILL || state == RUN);
  assign last_col  = (col == CW'(WIDTH - 1));
  assign last_row  = (row == RW'(DEPTH - 1));
  assign first_out = (row == RW'(1)) && (col == CW'(1));

  // Incoming pixel is (r+1,c+1); the center trails it by one row and one column.
  always_comb begin
    cc = (col == '0) ? CW'(WIDTH - 1) : col - CW'(1);
    cr = (col == '0) ? row - RW'(2) : row - RW'(1);
    border = (cc == '0) || (cc == CW'(WIDTH - 1)) || (cr == '0) || (cr == RW'(DEPTH - 1));
  end

  always_comb begin
    center = win[1][1][23:0];
    na = '0;
    nb = '0;
    unique case (win[1][1][25:24])
      2'b00: begin na = win[0][1][23:0]; nb = win[2][1][23:0]; end
      2'b01: begin na = win[1][0][23:0]; nb = win[1][2][23:0]; end
      2'b10: begin na = win[0][0][23:0]; nb = win[2][2][23:0]; end
      2'b11: begin na = win[0][2][23:0]; nb = win[2][0][23:0]; end
    endcase
    keep = (center >= na) && (center >= nb);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= grad_square;
      lb2[col] <= lb1[col];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      fcnt       <= '0;
      win        <= '{default: '0};
      v1         <= 1'b0;
      zero1      <= 1'b0;
      last1      <= 1'b0;
      nms_en     <= 1'b0;
      nms_out    <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else if (!start) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      fcnt       <= '0;
      win        <= '{default: '0};
      v1         <= 1'b0;
      zero1      <= 1'b0;
      last1      <= 1'b0;
      nms_en     <= 1'b0;
      nms_out    <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      v1    <= 1'b0;
      zero1 <= 1'b0;
      last1 <= 1'b0;
      unique case (state)
        IDLE: state <= FILL;
        FILL, RUN: begin
          if (data_en) begin
            for (int unsigned i = 0; i < 3; i++) begin
              win[i][0] <= win[i][1];
              win[i][1] <= win[i][2];
            end
            win[0][2] <= lb2[col];
            win[1][2] <= lb1[col];
            win[2][2] <= grad_square;
            col <= last_col ? '0 : col + CW'(1);
            row <= last_col ? row + RW'(1) : row;
            if (state == RUN || first_out) begin
              v1    <= 1'b1;
              zero1 <= border;
              state <= RUN;
            end
            if (state == RUN && last_row && last_col) begin
              state <= FLUSH;
              col   <= '0;
              row   <= '0;
              fcnt  <= '0;
            end
          end
        end
        FLUSH: begin
          // Remaining outputs are all border pixels; incoming data is dropped.
          if (data_en) overrun <= 1'b1;
          v1    <= 1'b1;
          zero1 <= 1'b1;
          fcnt  <= fcnt + FW'(1);
          if (fcnt == FW'(WIDTH)) begin
            last1 <= 1'b1;
            state <= FILL;
            fcnt  <= '0;
          end
        end
      endcase
      nms_en     <= v1;
      nms_out    <= (v1 && !zero1 && keep) ? center : '0;
      frame_done <= v1 && last1;
    end
  end

endmodule

// File: tb/tb_nms_thin.sv
// Self-checking bench for nms_thin at 4x4: table-driven frames, random frames with gaps,
// and hand sequences for overrun, start-low clear and mid-frame reset.
module tb_nms_thin;

  localparam int W = 4;
  localparam int D = 4;
  localparam int N = W * D;
  localparam logic [1:0] DN = 2'b00, DE = 2'b01, DNW = 2'b10, DNE = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        data_en = 1'b0;
  logic [25:0] grad_square = '0;
  logic        nms_en;
  logic [23:0] nms_out;
  logic        frame_done;
  logic        overrun;

  nms_thin #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_en(data_en),
    .grad_square(grad_square), .nms_en(nms_en), .nms_out(nms_out),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;
  logic [23:0] outq[$];
  int fd_idx[$];
  int unsigned first_cyc = 0;
  int unsigned t5 = 0;
  int zero_viol = 0;
  logic [25:0] frame [N];

  always @(negedge clk) begin
    if (nms_en) begin
      if (outq.size() == 0) first_cyc = cyc;
      if (frame_done) fd_idx.push_back(outq.size());
      outq.push_back(nms_out);
    end else begin
      if (nms_out != 0) zero_viol++;
      if (frame_done) fd_idx.push_back(-1);
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int mag_at(input int r, input int c);
    return int'(frame[r*W + c][23:0]);
  endfunction

  // Reference: direct 2-D lookup of the neighbour pair along the direction axis.
  function automatic int ref_out(input int p);
    int r, c, dr, dc, m, a, b;
    r = p / W;
    c = p % W;
    if (r == 0 || r == D-1 || c == 0 || c == W-1) return 0;
    case (frame[p][25:24])
      DN:      begin dr = 1;  dc = 0;  end
      DE:      begin dr = 0;  dc = 1;  end
      DNE:     begin dr = -1; dc = 1;  end
      default: begin dr = -1; dc = -1; end
    endcase
    m = mag_at(r, c);
    a = mag_at(r + dr, c + dc);
    b = mag_at(r - dr, c - dc);
    return (m >= a && m >= b) ? m : 0;
  endfunction

  task automatic clear_mon();
    outq.delete();
    fd_idx.delete();
  endtask

  // Entered and left at posedge+1.
  task automatic send_frame(input int npix, input int gap, input bit rgap, input int extra);
    for (int k = 0; k < npix; k++) begin
      data_en = 1'b1;
      grad_square = frame[k];
      if (k == 5) t5 = cyc;
      @(posedge clk); #1;
      data_en = 1'b0;
      repeat (rgap ? $urandom_range(0, gap) : gap) begin @(posedge clk); #1; end
    end
    if (extra > 0) begin
      data_en = 1'b1;
      grad_square = 26'h3ffffff;
      repeat (extra) begin @(posedge clk); #1; end
      data_en = 1'b0;
    end
  endtask

  task automatic wait_outputs(input int n);
    for (int i = 0; i < 300 && outq.size() < n; i++) @(posedge clk);
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string name);
    check({name, ":count"}, outq.size(), N);
    for (int p = 0; p < N; p++)
      check($sformatf("%s:pix%0d", name, p), (p < outq.size()) ? longint'(outq[p]) : -1, ref_out(p));
    check({name, ":frame_done_count"}, fd_idx.size(), 1);
    check({name, ":frame_done_pos"}, (fd_idx.size() > 0) ? fd_idx[0] : -2, N-1);
    check({name, ":latency"}, longint'(first_cyc) - longint'(t5), 2);
  endtask

  task automatic run_frame(input string name, input int gap, input bit rgap);
    clear_mon();
    send_frame(N, gap, rgap, 0);
    wait_outputs(N);
    check_frame(name);
  endtask

  task automatic random_frame();
    for (int p = 0; p < N; p++)
      frame[p] = {2'($urandom_range(0, 3)), 24'($urandom_range(0, 7))};
  endtask

  typedef struct {
    string      name;
    int         bmag;
    logic [1:0] bdir;
    int         p0; int m0; logic [1:0] d0;
    int         p1; int m1;
    int         p2; int m2;
    int         chk; int exp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{"uniform_c5",    100, DE, -1, 0,   DE,  -1, 0,  -1, 0,  5, 100};
    vecs[1] = '{"uniform_c0",    100, DE, -1, 0,   DE,  -1, 0,  -1, 0,  0, 0};
    vecs[2] = '{"uniform_c10",   100, DE, -1, 0,   DE,  -1, 0,  -1, 0,  10, 100};
    vecs[3] = '{"e_suppress_c5", 40,  DN, 5,  50,  DE,  4,  60, -1, 0,  5, 0};
    vecs[4] = '{"e_tie_c6",      40,  DN, 5,  50,  DE,  4,  60, -1, 0,  6, 40};
    vecs[5] = '{"ne_keep_c5",    90,  DE, 5,  50,  DNE, 2,  40, 8,  40, 5, 50};
    vecs[6] = '{"nw_supp_c10",   10,  DE, 10, 30,  DNW, 5,  31, -1, 0,  10, 0};
    vecs[7] = '{"n_tie_c6",      5,   DE, 6,  20,  DN,  2,  20, 10, 19, 6, 20};
    vecs[8] = '{"border_c4",     1,   DE, 4,  999, DE,  -1, 0,  -1, 0,  4, 0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_nms_en", nms_en, 0);
    check("reset_nms_out", nms_out, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_overrun", overrun, 0);
    rst_n = 1'b1;
    start = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    foreach (vecs[i]) begin
      for (int p = 0; p < N; p++) frame[p] = {vecs[i].bdir, 24'(vecs[i].bmag)};
      if (vecs[i].p0 >= 0) frame[vecs[i].p0] = {vecs[i].d0, 24'(vecs[i].m0)};
      if (vecs[i].p1 >= 0) frame[vecs[i].p1][23:0] = 24'(vecs[i].m1);
      if (vecs[i].p2 >= 0) frame[vecs[i].p2][23:0] = 24'(vecs[i].m2);
      run_frame(vecs[i].name, 0, 1'b0);
      check({vecs[i].name, ":target"}, (vecs[i].chk < outq.size()) ? longint'(outq[vecs[i].chk]) : -1, vecs[i].exp);
    end

    for (int p = 0; p < N; p++) frame[p] = {DE, 24'd100};
    run_frame("uniform_gap3", 3, 1'b0);

    for (int i = 0; i < 6; i++) begin
      random_frame();
      run_frame($sformatf("random%0d", i), 3, 1'b1);
    end

    // Input during flush is dropped and flagged; start low clears the flag.
    random_frame();
    clear_mon();
    send_frame(N, 0, 1'b0, 2);
    wait_outputs(N);
    check_frame("overrun_frame");
    check("overrun_set", overrun, 1);
    start = 1'b0;
    @(posedge clk); #1;
    check("start_low_overrun", overrun, 0);
    check("start_low_nms_en", nms_en, 0);
    start = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    random_frame();
    run_frame("after_start_low", 1, 1'b1);

    // Mid-frame reset with overrun set and outputs active.
    random_frame();
    clear_mon();
    send_frame(N, 0, 1'b0, 1);
    wait_outputs(N);
    check("overrun_set2", overrun, 1);
    send_frame(8, 0, 1'b0, 0);
    check("pre_reset_nms_en", nms_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_nms_en", nms_en, 0);
    check("midreset_nms_out", nms_out, 0);
    check("midreset_frame_done", frame_done, 0);
    check("midreset_overrun", overrun, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    random_frame();
    run_frame("after_reset", 2, 1'b1);

    check("nms_out_zero_when_idle", zero_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
